// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// The hazard counters exist only when HAZARD_STAT_EN is defined.
interface id_ex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 3
);
  // ID-side (towards the register)
  logic               hold_i;
  logic               flush_i;
  logic               valid_i;
  logic [DATA_W-1:0]  pc_i;
  logic [DATA_W-1:0]  RSdata_i;
  logic [DATA_W-1:0]  RTdata_i;
  logic [DATA_W-1:0]  imm_i;
  logic [ADDR_W-1:0]  RSaddr_i;
  logic [ADDR_W-1:0]  RTaddr_i;
  logic [ADDR_W-1:0]  RDaddr_i;
  logic               uses_rs_i;
  logic               uses_rt_i;
  logic               RegWrite_i;
  logic               MemToReg_i;
  logic               MemRead_i;
  logic               MemWrite_i;
  logic               ALUSrc_i;
  logic               RegDst_i;
  logic [ALUOP_W-1:0] ALUOp_i;

  // EX-side (from the register)
  logic               stall_o;
  logic               valid_o;
  logic [DATA_W-1:0]  pc_o;
  logic [DATA_W-1:0]  RSdata_o;
  logic [DATA_W-1:0]  RTdata_o;
  logic [DATA_W-1:0]  imm_o;
  logic [ADDR_W-1:0]  RSaddr_o;
  logic [ADDR_W-1:0]  RTaddr_o;
  logic [ADDR_W-1:0]  WBaddr_o;
  logic               RegWrite_o;
  logic               MemToReg_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               ALUSrc_o;
  logic [ALUOP_W-1:0] ALUOp_o;
`ifdef HAZARD_STAT_EN
  logic [31:0]        stall_cnt_o;
  logic [31:0]        flush_cnt_o;
`endif

  // Decode/ID side: drives instruction fields, observes the EX copy and stall
  modport master (
    output hold_i, flush_i, valid_i, pc_i, RSdata_i, RTdata_i, imm_i,
           RSaddr_i, RTaddr_i, RDaddr_i, uses_rs_i, uses_rt_i,
           RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
    input  stall_o, valid_o, pc_o, RSdata_o, RTdata_o, imm_o,
           RSaddr_o, RTaddr_o, WBaddr_o,
           RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o
`ifdef HAZARD_STAT_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );

  // Pipeline register side
  modport slave (
    input  hold_i, flush_i, valid_i, pc_i, RSdata_i, RTdata_i, imm_i,
           RSaddr_i, RTaddr_i, RDaddr_i, uses_rs_i, uses_rt_i,
           RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
    output stall_o, valid_o, pc_o, RSdata_o, RTdata_o, imm_o,
           RSaddr_o, RTaddr_o, WBaddr_o,
           RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o
`ifdef HAZARD_STAT_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core with load-use
// hazard detection, branch flush and global hold.
// Optional macro HAZARD_STAT_EN adds saturating stall/flush bubble counters.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  rs_addr;
    logic [ADDR_W-1:0]  rt_addr;
    logic [ADDR_W-1:0]  wb_addr;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  ex_t  ex_cap;
  logic hz;
  logic stall;

  // Load-use hazard: the load in EX targets a register the ID instruction reads.
  // Only EX needs checking; later stages are covered by forwarding and the
  // register file's write-through.
  always_comb begin
    hz = ex_q.valid && ex_q.mem_read && (ex_q.wb_addr != '0) &&
         ((bus.uses_rs_i && (bus.RSaddr_i == ex_q.wb_addr)) ||
          (bus.uses_rt_i && (bus.RTaddr_i == ex_q.wb_addr)));
    // A flushed instruction is dead, so it never needs to wait for the load
    stall = hz && bus.valid_i && !bus.flush_i && !rst_i;
  end

  // Value loaded on a normal edge: controls only survive for a real instruction
  always_comb begin
    ex_cap            = '0;
    ex_cap.valid      = bus.valid_i;
    ex_cap.pc         = bus.pc_i;
    ex_cap.rs_data    = bus.RSdata_i;
    ex_cap.rt_data    = bus.RTdata_i;
    ex_cap.imm        = bus.imm_i;
    ex_cap.rs_addr    = bus.RSaddr_i;
    ex_cap.rt_addr    = bus.RTaddr_i;
    ex_cap.wb_addr    = bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i;
    ex_cap.reg_write  = bus.valid_i & bus.RegWrite_i;
    ex_cap.mem_to_reg = bus.valid_i & bus.MemToReg_i;
    ex_cap.mem_read   = bus.valid_i & bus.MemRead_i;
    ex_cap.mem_write  = bus.valid_i & bus.MemWrite_i;
    ex_cap.alu_src    = bus.valid_i & bus.ALUSrc_i;
    ex_cap.alu_op     = bus.valid_i ? bus.ALUOp_i : '0;
  end

  // Next-state priority: hold freezes everything, then flush/stall bubble, else capture
  always_comb begin
    ex_d = ex_q;
    if (!bus.hold_i) begin
      if (bus.flush_i || stall) begin
        ex_d = '0;
      end else begin
        ex_d = ex_cap;
      end
    end
  end

  // Pipeline register; reset clears to a bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.valid_o    = ex_q.valid;
  assign bus.pc_o       = ex_q.pc;
  assign bus.RSdata_o   = ex_q.rs_data;
  assign bus.RTdata_o   = ex_q.rt_data;
  assign bus.imm_o      = ex_q.imm;
  assign bus.RSaddr_o   = ex_q.rs_addr;
  assign bus.RTaddr_o   = ex_q.rt_addr;
  assign bus.WBaddr_o   = ex_q.wb_addr;
  assign bus.RegWrite_o = ex_q.reg_write;
  assign bus.MemToReg_o = ex_q.mem_to_reg;
  assign bus.MemRead_o  = ex_q.mem_read;
  assign bus.MemWrite_o = ex_q.mem_write;
  assign bus.ALUSrc_o   = ex_q.alu_src;
  assign bus.ALUOp_o    = ex_q.alu_op;

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Count inserted bubbles by cause; a flush takes precedence over a stall
  // (stall is already masked by flush) and a held edge inserts nothing
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.hold_i) begin
      if (bus.flush_i) begin
        if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (stall) begin
        if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized bench for id_ex_stage with a
// cycle-level reference model of the ID/EX register.
module tb_id_ex_stage;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 3;

  logic clk;
  logic rst;

  id_ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of what EX should hold
  typedef struct {
    bit          valid;
    bit [31:0]   pc, rsd, rtd, imm;
    bit [4:0]    rsa, rta, wba;
    bit          rw, m2r, mr, mw, als;
    bit [2:0]    aluop;
  } ex_m_t;

  ex_m_t m;
  bit [31:0] m_scnt, m_fcnt;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    bit rd;
    rd = (bus.uses_rs_i && bus.RSaddr_i == m.wba) || (bus.uses_rt_i && bus.RTaddr_i == m.wba);
    return !rst && bus.valid_i && !bus.flush_i && m.valid && m.mr && (m.wba != 0) && rd;
  endfunction

  task automatic model_edge(input bit st);
    ex_m_t z;
    z = '{default: 0};
    if (rst) begin
      m = z; m_scnt = 0; m_fcnt = 0;
    end else if (bus.hold_i) begin
      // frozen
    end else if (bus.flush_i) begin
      m = z;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end else if (st) begin
      m = z;
      if (m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end else begin
      m.valid = bus.valid_i;
      m.pc = bus.pc_i; m.rsd = bus.RSdata_i; m.rtd = bus.RTdata_i; m.imm = bus.imm_i;
      m.rsa = bus.RSaddr_i; m.rta = bus.RTaddr_i;
      m.wba = bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i;
      m.rw  = bus.valid_i && bus.RegWrite_i;
      m.m2r = bus.valid_i && bus.MemToReg_i;
      m.mr  = bus.valid_i && bus.MemRead_i;
      m.mw  = bus.valid_i && bus.MemWrite_i;
      m.als = bus.valid_i && bus.ALUSrc_i;
      m.aluop = bus.valid_i ? bus.ALUOp_i : 3'd0;
    end
  endtask

  task automatic check_outputs();
    chk("valid_o", bus.valid_o, m.valid);
    chk("pc_o", bus.pc_o, m.pc);
    chk("RSdata_o", bus.RSdata_o, m.rsd);
    chk("RTdata_o", bus.RTdata_o, m.rtd);
    chk("imm_o", bus.imm_o, m.imm);
    chk("addr_o", {bus.RSaddr_o, bus.RTaddr_o, bus.WBaddr_o}, {m.rsa, m.rta, m.wba});
    chk("ctrl_o", {bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o, bus.ALUSrc_o},
        {m.rw, m.m2r, m.mr, m.mw, m.als});
    chk("ALUOp_o", bus.ALUOp_o, m.aluop);
`ifdef HAZARD_STAT_EN
    chk("stall_cnt_o", bus.stall_cnt_o, m_scnt);
    chk("flush_cnt_o", bus.flush_cnt_o, m_fcnt);
`endif
  endtask

  // One clock: check combinational stall before the edge, then registered outputs after
  task automatic tick();
    bit st;
    @(negedge clk);
    st = model_stall();
    chk("stall_o", bus.stall_o, st);
    model_edge(st);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    bus.hold_i = 0; bus.flush_i = 0; bus.valid_i = 0;
    bus.pc_i = 0; bus.RSdata_i = 0; bus.RTdata_i = 0; bus.imm_i = 0;
    bus.RSaddr_i = 0; bus.RTaddr_i = 0; bus.RDaddr_i = 0;
    bus.uses_rs_i = 0; bus.uses_rt_i = 0;
    bus.RegWrite_i = 0; bus.MemToReg_i = 0; bus.MemRead_i = 0; bus.MemWrite_i = 0;
    bus.ALUSrc_i = 0; bus.RegDst_i = 0; bus.ALUOp_i = 0;
  endtask

  // Random instruction; small address range so hazards occur often
  task automatic set_rand_instr();
    bus.valid_i = ($urandom_range(0, 9) != 0);
    bus.pc_i = $urandom; bus.RSdata_i = $urandom; bus.RTdata_i = $urandom; bus.imm_i = $urandom;
    bus.RSaddr_i = 5'($urandom_range(0, 3));
    bus.RTaddr_i = 5'($urandom_range(0, 3));
    bus.RDaddr_i = 5'($urandom_range(0, 3));
    bus.uses_rs_i = 1'($urandom); bus.uses_rt_i = 1'($urandom);
    bus.RegWrite_i = 1'($urandom); bus.MemToReg_i = 1'($urandom);
    bus.MemRead_i = ($urandom_range(0, 2) != 0);
    bus.MemWrite_i = 1'($urandom); bus.ALUSrc_i = 1'($urandom);
    bus.RegDst_i = 1'($urandom); bus.ALUOp_i = 3'($urandom);
  endtask

  task automatic set_lw(input bit [4:0] rt);
    set_idle();
    bus.valid_i = 1; bus.MemRead_i = 1; bus.MemToReg_i = 1; bus.RegWrite_i = 1;
    bus.ALUSrc_i = 1; bus.RegDst_i = 0; bus.RTaddr_i = rt; bus.RSaddr_i = 5'd1;
    bus.uses_rs_i = 1; bus.imm_i = 32'h10; bus.pc_i = 32'h100; bus.ALUOp_i = 3'd2;
  endtask

  task automatic set_add(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt);
    set_idle();
    bus.valid_i = 1; bus.RSaddr_i = rs; bus.RTaddr_i = rt; bus.RDaddr_i = 5'd7;
    bus.uses_rs_i = urs; bus.uses_rt_i = urt; bus.RegDst_i = 1; bus.RegWrite_i = 1;
    bus.RSdata_i = 32'hA5A5; bus.RTdata_i = 32'h5A5A; bus.pc_i = 32'h104; bus.ALUOp_i = 3'd1;
  endtask

  initial begin
    m = '{default: 0};
    m_scnt = 0; m_fcnt = 0;
    set_idle();
    rst = 1;

    // Reset with random inputs
    set_rand_instr();
    tick();
    set_rand_instr();
    tick();
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_stall", bus.stall_o, 1'b0);
    rst = 0;

    // Normal capture
    set_idle();
    bus.valid_i = 1; bus.RSdata_i = 32'h11; bus.RTdata_i = 32'h22;
    bus.RegDst_i = 1; bus.RDaddr_i = 5'd3; bus.RegWrite_i = 1;
    tick();
    chk("cap_RSdata", bus.RSdata_o, 32'h11);
    chk("cap_RTdata", bus.RTdata_o, 32'h22);
    chk("cap_WBaddr", bus.WBaddr_o, 5'd3);
    chk("cap_RegWrite", bus.RegWrite_o, 1'b1);
    chk("cap_valid", bus.valid_o, 1'b1);

    // Load-use on RS: stall one cycle then capture
    set_lw(5'd5);
    tick();
    set_add(5'd5, 5'd6, 1, 1);
    #1;
    chk("lu_stall_hi", bus.stall_o, 1'b1);
    tick();
    chk("lu_bubble_valid", bus.valid_o, 1'b0);
    chk("lu_bubble_memread", bus.MemRead_o, 1'b0);
    #1;
    chk("lu_stall_lo", bus.stall_o, 1'b0);
    tick();
    chk("lu_cap_RSaddr", bus.RSaddr_o, 5'd5);
    chk("lu_cap_valid", bus.valid_o, 1'b1);

    // No false stall: load to $0, and RT match without uses_rt
    set_lw(5'd0);
    tick();
    set_add(5'd0, 5'd0, 1, 1);
    #1;
    chk("nf_zero", bus.stall_o, 1'b0);
    tick();
    set_lw(5'd5);
    tick();
    set_add(5'd2, 5'd5, 1, 0);
    #1;
    chk("nf_unused_rt", bus.stall_o, 1'b0);
    tick();

    // Flush with a hazard present
    set_lw(5'd5);
    tick();
    set_add(5'd5, 5'd5, 1, 1);
    bus.flush_i = 1;
    #1;
    chk("fl_stall", bus.stall_o, 1'b0);
    tick();
    chk("fl_valid", bus.valid_o, 1'b0);

    // Hold with a pending hazard, then hold with flush
    set_lw(5'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_add(5'd5, 5'($urandom_range(0, 31)), 1, 1);
      bus.RSdata_i = $urandom;
      bus.hold_i = 1;
      #1;
      chk("hold_stall", bus.stall_o, 1'b1);
      tick();
      chk("hold_memread", bus.MemRead_o, 1'b1);
    end
    bus.flush_i = 1;
    tick();
    chk("hold_flush_valid", bus.valid_o, 1'b1);
    set_idle();
    tick();

    // Reset in the middle of a stall
    set_lw(5'd4);
    tick();
    set_add(5'd4, 5'd1, 1, 0);
    rst = 1;
    #1;
    chk("rst_mid_stall", bus.stall_o, 1'b0);
    tick();
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_rand_instr();
      bus.hold_i  = ($urandom_range(0, 7) == 0);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
